// File: rtl/johnson_pkg.sv
// johnson_pkg: shared constants plus seed/encode helpers for the Johnson/ring sequence generator.
package johnson_pkg;
    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_FWD      = 1'b0;
    localparam logic DIR_REV      = 1'b1;
    localparam int   MAXN         = 32;

    function automatic logic [MAXN-1:0] seed(input logic mode);
        return {{(MAXN-1){1'b0}}, mode};
    endfunction

    // Johnson phase k<=n sets the low k bits; phase k>n clears the low k-n bits of all-ones.
    function automatic logic [MAXN-1:0] encode(input int n, input logic mode, input int ph);
        logic [MAXN-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[i] = (mode == MODE_RING) ? (i == ph) : ((ph <= n) ? (i < ph) : (i >= ph - n));
        return r;
    endfunction
endpackage

// File: rtl/johnson_seq_gen_if.sv
// johnson_seq_gen_if: control and status bundle of the sequence generator.
interface johnson_seq_gen_if #(parameter int N = 4, parameter int PW = $clog2(2*N));
    logic          en;
    logic          dir;
    logic          mode;
    logic          load;
    logic [PW-1:0] load_phase;
    logic [N-1:0]  out;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;

    modport master (output en, dir, mode, load, load_phase, input out, phase, wrap, err);
    modport slave  (input en, dir, mode, load, load_phase, output out, phase, wrap, err);
endinterface

// File: rtl/johnson_phase_decode.sv
// johnson_phase_decode: state to binary phase index, plus legality of the state for the mode.
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(2*N)
) (
    input  logic [N-1:0]  i_out,
    input  logic          i_mode,
    output logic [PW-1:0] o_phase,
    output logic          o_legal
);
    logic [PW-1:0] w_cnt;
    logic [PW-1:0] w_idx;

    always_comb begin
        w_cnt = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + PW'(i_out[i]);
            if (i_out[i]) w_idx = PW'(i);
        end
    end

    // Upper Johnson half: N + zero count, i.e. 2N - popcount.
    assign o_phase = (i_mode == MODE_RING) ? w_idx : (i_out[N-1] ? PW'(2*N) - w_cnt : w_cnt);
    assign o_legal = (i_mode == MODE_RING) ? (w_cnt == PW'(1))
                                           : (i_out == N'(encode(N, i_mode, int'(o_phase))));
endmodule

// File: rtl/johnson_seq_gen.sv
// johnson_seq_gen: N-bit Johnson/ring sequencer; define JOHNSON_SELF_CORRECT_EN for illegal-state recovery.
module johnson_seq_gen
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(2*N)
) (
    input logic               clk,
    input logic               reset,
    johnson_seq_gen_if.slave  bus
);
    logic [N-1:0]  r_out;
    logic          r_mode;
    logic          r_wrap;
    logic          r_err;
    logic [N-1:0]  w_next;
    logic [N-1:0]  w_fwd;
    logic [N-1:0]  w_rev;
    logic [N-1:0]  w_step;
    logic [N-1:0]  w_enc;
    logic [PW-1:0] w_phase;
    logic          w_legal;
    logic          w_ill;
    logic          w_ld_ok;
    logic          w_wrap;
    logic          w_err;

    johnson_phase_decode #(.N(N), .PW(PW)) u_dec (
        .i_out   (r_out),
        .i_mode  (r_mode),
        .o_phase (w_phase),
        .o_legal (w_legal)
    );

`ifdef JOHNSON_SELF_CORRECT_EN
    assign w_ill = ~w_legal;
`else
    logic w_unused;
    assign w_unused = w_legal;
    assign w_ill    = 1'b0;
`endif

    assign w_fwd   = {r_out[N-2:0], (r_mode == MODE_RING) ? r_out[N-1] : ~r_out[N-1]};
    assign w_rev   = {(r_mode == MODE_RING) ? r_out[0] : ~r_out[0], r_out[N-1:1]};
    assign w_step  = (bus.dir == DIR_REV) ? w_rev : w_fwd;
    assign w_enc   = N'(encode(N, r_mode, int'(bus.load_phase)));
    assign w_ld_ok = int'(bus.load_phase) < ((r_mode == MODE_RING) ? N : 2*N);

    always_comb begin
        w_next = r_out;
        w_wrap = 1'b0;
        w_err  = 1'b0;
        if (bus.mode != r_mode)
            w_next = N'(seed(bus.mode));
        else if (w_ill) begin
            w_next = N'(seed(r_mode));
            w_err  = 1'b1;
        end else if (bus.load)
            w_next = w_ld_ok ? w_enc : r_out;
        else if (bus.en) begin
            w_next = w_step;
            w_wrap = w_step == N'(seed(r_mode));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out  <= N'(seed(bus.mode));
            r_mode <= bus.mode;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_out  <= w_next;
            r_mode <= bus.mode;
            r_wrap <= w_wrap;
            r_err  <= w_err;
        end
    end

    assign bus.out   = r_out;
    assign bus.phase = w_phase;
    assign bus.wrap  = r_wrap;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_johnson_seq_gen.sv
// tb_johnson_seq_gen: directed and randomized checks of johnson_seq_gen against a phase-level model.
module tb_johnson_seq_gen;
    localparam int N  = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   m_p = 0;
    logic m_mode = 1'b0;
    logic m_wrap = 1'b0;

    always #5 clk = ~clk;

    johnson_seq_gen_if #(.N(N), .PW(PW)) bus();
    johnson_seq_gen #(.N(N), .PW(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Model holds only the phase index; the state pattern is derived from it.
    function automatic logic [N-1:0] m_enc(input int p, input logic md);
        if (md) return N'(1 << p);
        return (p <= N) ? N'((1 << p) - 1) : N'(15 ^ ((1 << (p - N)) - 1));
    endfunction

    task automatic tick(input logic rs, input logic e, input logic d, input logic md,
                        input logic ld, input int lp);
        int per;
        reset = rs; bus.en = e; bus.dir = d; bus.mode = md; bus.load = ld;
        bus.load_phase = PW'(lp);
        @(posedge clk);
        per = m_mode ? N : 2*N;
        if (!rs || md !== m_mode) begin
            m_mode = md; m_p = 0; m_wrap = 1'b0;
        end else if (ld) begin
            if (lp < per) m_p = lp;
            m_wrap = 1'b0;
        end else if (e) begin
            m_p = d ? (m_p + per - 1) % per : (m_p + 1) % per;
            m_wrap = (m_p == 0);
        end else m_wrap = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tests++; if (bus.out !== 4'b0000) begin fails++; $display("FAIL reset out: got %b want 0000", bus.out); end
        tests++; if (bus.phase !== 3'd0) begin fails++; $display("FAIL reset phase: got %0d want 0", bus.phase); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL reset wrap: got %b want 0", bus.wrap); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", bus.err); end
    endtask

    task automatic test_johnson_fwd;
        logic [3:0] exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            tick(1, 1, 0, 0, 0, 0);
            tests++; if (bus.out !== exp[i]) begin fails++; $display("FAIL fwd out step %0d: got %b want %b", i, bus.out, exp[i]); end
            tests++; if (int'(bus.phase) != (i + 1) % 8) begin fails++; $display("FAIL fwd phase step %0d: got %0d want %0d", i, bus.phase, (i + 1) % 8); end
            tests++; if (bus.wrap !== (i == 7)) begin fails++; $display("FAIL fwd wrap step %0d: got %b want %b", i, bus.wrap, i == 7); end
        end
    endtask

    task automatic test_johnson_rev;
        logic [3:0] exp [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1000};
        tick(1, 0, 0, 0, 1, 3);
        tests++; if (bus.out !== 4'b0111) begin fails++; $display("FAIL rev load3: got %b want 0111", bus.out); end
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 1, 0, 0, 0);
            tests++; if (bus.out !== exp[i]) begin fails++; $display("FAIL rev out step %0d: got %b want %b", i, bus.out, exp[i]); end
            tests++; if (bus.wrap !== (i == 2)) begin fails++; $display("FAIL rev wrap step %0d: got %b want %b", i, bus.wrap, i == 2); end
        end
    endtask

    task automatic test_mode_change;
        logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tick(1, 0, 0, 0, 1, 2);
        tick(1, 1, 0, 1, 1, 1);
        tests++; if (bus.out !== 4'b0001) begin fails++; $display("FAIL mode reinit out: got %b want 0001", bus.out); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL mode reinit wrap: got %b want 0", bus.wrap); end
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 0, 1, 0, 0);
            tests++; if (bus.out !== exp[i]) begin fails++; $display("FAIL ring out step %0d: got %b want %b", i, bus.out, exp[i]); end
            tests++; if (int'(bus.phase) != (i + 1) % 4) begin fails++; $display("FAIL ring phase step %0d: got %0d want %0d", i, bus.phase, (i + 1) % 4); end
            tests++; if (bus.wrap !== (i == 3)) begin fails++; $display("FAIL ring wrap step %0d: got %b want %b", i, bus.wrap, i == 3); end
        end
    endtask

    task automatic test_load;
        tick(1, 1, 0, 1, 1, 6);
        tests++; if (bus.out !== 4'b0001) begin fails++; $display("FAIL ring load6 hold: got %b want 0001", bus.out); end
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 1, 5);
        tests++; if (bus.out !== 4'b1110) begin fails++; $display("FAIL load5 out: got %b want 1110", bus.out); end
        tests++; if (bus.phase !== 3'd5) begin fails++; $display("FAIL load5 phase: got %0d want 5", bus.phase); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL load5 wrap: got %b want 0", bus.wrap); end
        tick(1, 1, 0, 0, 1, 0);
        tests++; if (bus.out !== 4'b0000) begin fails++; $display("FAIL load0 out: got %b want 0000", bus.out); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL load0 wrap: got %b want 0", bus.wrap); end
    endtask

    task automatic test_self_correct;
        logic [3:0] exp_out;
        logic       exp_err;
`ifdef JOHNSON_SELF_CORRECT_EN
        exp_out = 4'b0000; exp_err = 1'b1;
`else
        exp_out = 4'b1011; exp_err = 1'b0;
`endif
        force dut.r_out = 4'b0101;
        #1;
        release dut.r_out;
        tick(1, 1, 0, 0, 0, 0);
        tests++; if (bus.out !== exp_out) begin fails++; $display("FAIL illegal out: got %b want %b", bus.out, exp_out); end
        tests++; if (bus.err !== exp_err) begin fails++; $display("FAIL illegal err: got %b want %b", bus.err, exp_err); end
        tick(1, 0, 0, 0, 0, 0);
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL illegal err pulse: got %b want 0", bus.err); end
    endtask

    task automatic test_reset_mid;
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 7);
        tick(0, 1, 0, 0, 0, 0);
        tests++; if (bus.out !== 4'b0000) begin fails++; $display("FAIL midreset out: got %b want 0000", bus.out); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL midreset wrap: got %b want 0", bus.wrap); end
        tick(1, 0, 0, 0, 1, 6);
        tick(0, 1, 0, 1, 0, 0);
        tests++; if (bus.out !== 4'b0001) begin fails++; $display("FAIL midreset ring out: got %b want 0001", bus.out); end
        tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL midreset ring wrap: got %b want 0", bus.wrap); end
    endtask

    task automatic test_random;
        logic [N-1:0] eo;
        for (int i = 0; i < 300; i++) begin
            tick(logic'($urandom_range(0, 24) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)), m_mode ^ ($urandom_range(0, 11) == 0),
                 logic'($urandom_range(0, 4) == 0), int'($urandom_range(0, 7)));
            eo = m_enc(m_p, m_mode);
            tests++; if (bus.out !== eo) begin fails++; $display("FAIL rand out cyc %0d: got %b want %b", i, bus.out, eo); end
            tests++; if (int'(bus.phase) != m_p) begin fails++; $display("FAIL rand phase cyc %0d: got %0d want %0d", i, bus.phase, m_p); end
            tests++; if (bus.wrap !== m_wrap) begin fails++; $display("FAIL rand wrap cyc %0d: got %b want %b", i, bus.wrap, m_wrap); end
            tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL rand err cyc %0d: got %b want 0", i, bus.err); end
        end
    endtask

    initial begin
        test_reset;
        test_johnson_fwd;
        test_johnson_rev;
        test_mode_change;
        test_load;
        test_self_correct;
        test_reset_mid;
        tick(0, 0, 0, 0, 0, 0);
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
